// File: rtl/au_cnt_gray_dn.sv
// Gray-code down-counter with load, wrap/saturate-at-zero, terminal-count pulse
// and a one-cycle-lagged binary view of the count.
module au_cnt_gray_dn #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int SAT   = 0,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             tc,
  output logic [WIDTH-1:0] cnt_bin,
  output logic             bin_vld
);

  logic             parity;
  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] cnt_dec;
  logic [WIDTH-1:0] cnt_as_bin;
  logic             vld_pipe;

  assign zero   = (cnt == '0);
  assign parity = ^cnt;

  // Isolate the lowest set bit; the three variants are functionally identical.
  generate
    if (ARCH == 1) begin : g_twos
      assign low_bit = cnt & (~cnt + WIDTH'(1));
    end else if (ARCH == 2) begin : g_prefix
      logic [WIDTH-1:0] seen;
      always_comb begin
        seen    = '0;
        low_bit = '0;
        for (int i = 1; i < WIDTH; i++) seen[i] = seen[i-1] | cnt[i-1];
        low_bit = cnt & ~seen;
      end
    end else begin : g_scan
      always_comb begin
        logic found;
        found   = 1'b0;
        low_bit = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt[i] && !found) begin
            low_bit[i] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Odd parity flips bit 0; even parity flips the bit left of the lowest set bit.
  always_comb begin
    flip = '0;
    if (parity) begin
      flip[0] = 1'b1;
    end else if (zero) begin
      flip[WIDTH-1] = 1'b1;
    end else if (low_bit[WIDTH-1]) begin
      flip = low_bit;
    end else begin
      flip = low_bit << 1;
    end
    cnt_dec = cnt ^ flip;
  end

  always_comb begin
    cnt_as_bin = '0;
    cnt_as_bin[WIDTH-1] = cnt[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) cnt_as_bin[i] = cnt_as_bin[i+1] ^ cnt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= INIT;
      tc       <= 1'b0;
      cnt_bin  <= '0;
      vld_pipe <= 1'b0;
      bin_vld  <= 1'b0;
    end else begin
      cnt_bin  <= cnt_as_bin;
      vld_pipe <= 1'b1;
      bin_vld  <= vld_pipe;
      tc       <= en && !load && zero;
      if (load) begin
        cnt <= ld_val;
      end else if (en && !((SAT != 0) && zero)) begin
        cnt <= cnt_dec;
      end
    end
  end

endmodule

// File: tb/tb_au_cnt_gray_dn.sv
// Directed bench: wrapping 4-bit counter via vector table, plus hand sequences
// for the full cycle, saturating mode with non-zero INIT, and WIDTH=1.
module tb_au_cnt_gray_dn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // u0: WIDTH=4, SAT=0, INIT=0
  logic       rst0 = 1'b1, load0 = 1'b0, en0 = 1'b0;
  logic [3:0] ld0 = '0;
  logic [3:0] cnt0, bin0;
  logic       zero0, tc0, vld0;

  // u1: WIDTH=4, SAT=1, INIT=0101
  logic       rst1 = 1'b1, load1 = 1'b0, en1 = 1'b0;
  logic [3:0] ld1 = '0;
  logic [3:0] cnt1, bin1;
  logic       zero1, tc1, vld1;

  // u2: WIDTH=1
  logic       rst2 = 1'b1, load2 = 1'b0, en2 = 1'b0;
  logic [0:0] ld2 = '0;
  logic [0:0] cnt2, bin2;
  logic       zero2, tc2, vld2;

  au_cnt_gray_dn #(.WIDTH(4), .ARCH(0), .SAT(0), .INIT(4'b0000)) u0 (
    .clk(clk), .rst(rst0), .load(load0), .ld_val(ld0), .en(en0),
    .cnt(cnt0), .zero(zero0), .tc(tc0), .cnt_bin(bin0), .bin_vld(vld0));

  au_cnt_gray_dn #(.WIDTH(4), .ARCH(1), .SAT(1), .INIT(4'b0101)) u1 (
    .clk(clk), .rst(rst1), .load(load1), .ld_val(ld1), .en(en1),
    .cnt(cnt1), .zero(zero1), .tc(tc1), .cnt_bin(bin1), .bin_vld(vld1));

  au_cnt_gray_dn #(.WIDTH(1), .ARCH(2), .SAT(0), .INIT(1'b0)) u2 (
    .clk(clk), .rst(rst2), .load(load2), .ld_val(ld2), .en(en2),
    .cnt(cnt2), .zero(zero2), .tc(tc2), .cnt_bin(bin2), .bin_vld(vld2));

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic [3:0] ld_val;
    logic [3:0] cnt;
    logic       tc;
    logic       zero;
    logic [3:0] bin;
    logic       vld;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev_cnt;
    logic [3:0] b_exp;
    logic [3:0] b_prev;
    logic [3:0] g_exp;
    logic [15:0] seen;

    //            rst   load  en    ld_val   cnt      tc    zero  bin   vld
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'd0,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'd15, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1011, 1'b0, 1'b0, 4'd14, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1010, 1'b0, 1'b0, 4'd13, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010, 1'b0, 1'b0, 4'd12, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'd12, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b0, 4'd4,  1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'd4,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'd3,  1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'd2,  1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd1,  1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'd0,  1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 4'b0101, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0,  1'b0};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst0 = vecs[i].rst; load0 = vecs[i].load; en0 = vecs[i].en; ld0 = vecs[i].ld_val;
      tick();
      check($sformatf("v%0d cnt", i),     32'(cnt0),  32'(vecs[i].cnt));
      check($sformatf("v%0d tc", i),      32'(tc0),   32'(vecs[i].tc));
      check($sformatf("v%0d zero", i),    32'(zero0), 32'(vecs[i].zero));
      check($sformatf("v%0d cnt_bin", i), 32'(bin0),  32'(vecs[i].bin));
      check($sformatf("v%0d bin_vld", i), 32'(vld0),  32'(vecs[i].vld));
    end

    // Full 16-step cycle from zero with en held.
    b_prev   = 4'd0;
    prev_cnt = cnt0;
    seen     = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      en0 = 1'b1;
      tick();
      b_exp = 4'(16 - i);
      g_exp = b_exp ^ (b_exp >> 1);
      check($sformatf("full%0d cnt", i),     32'(cnt0), 32'(g_exp));
      check($sformatf("full%0d onebit", i),  32'($countones(cnt0 ^ prev_cnt)), 32'd1);
      check($sformatf("full%0d cnt_bin", i), 32'(bin0), 32'(b_prev));
      check($sformatf("full%0d zero", i),    32'(zero0), 32'(b_exp == 4'd0));
      check($sformatf("full%0d tc", i),      32'(tc0), 32'(i == 1));
      seen[cnt0] = 1'b1;
      prev_cnt = cnt0;
      b_prev   = b_exp;
    end
    check("full visited", 32'(seen), 32'h0000_ffff);
    @(negedge clk);
    en0 = 1'b0;

    // Saturating counter with non-zero INIT.
    @(negedge clk);
    rst1 = 1'b1;
    tick();
    check("sat init cnt", 32'(cnt1), 32'b0101);
    check("sat init vld", 32'(vld1), 32'd0);
    @(negedge clk);
    rst1 = 1'b0; load1 = 1'b1; ld1 = 4'b0001;
    tick();
    check("sat load cnt", 32'(cnt1), 32'b0001);
    @(negedge clk);
    load1 = 1'b0; en1 = 1'b1;
    tick();
    check("sat en1 cnt", 32'(cnt1), 32'b0000);
    check("sat en1 tc", 32'(tc1), 32'd0);
    tick();
    check("sat en2 cnt", 32'(cnt1), 32'b0000);
    check("sat en2 tc", 32'(tc1), 32'd1);
    tick();
    check("sat en3 cnt", 32'(cnt1), 32'b0000);
    check("sat en3 tc", 32'(tc1), 32'd1);
    @(negedge clk);
    en1 = 1'b0;
    tick();
    check("sat idle tc", 32'(tc1), 32'd0);
    @(negedge clk);
    load1 = 1'b1; ld1 = 4'b0110;
    tick();
    @(negedge clk);
    load1 = 1'b0; en1 = 1'b1;
    tick();
    check("sat dec cnt", 32'(cnt1), 32'b0010);
    check("sat dec bin", 32'(bin1), 32'd4);
    @(negedge clk);
    en1 = 1'b0;

    // Single-bit counter.
    @(negedge clk);
    rst2 = 1'b1;
    tick();
    check("w1 rst cnt", 32'(cnt2), 32'd0);
    @(negedge clk);
    rst2 = 1'b0; en2 = 1'b1;
    tick();
    check("w1 en1 cnt", 32'(cnt2), 32'd1);
    check("w1 en1 tc", 32'(tc2), 32'd1);
    tick();
    check("w1 en2 cnt", 32'(cnt2), 32'd0);
    check("w1 en2 tc", 32'(tc2), 32'd0);
    check("w1 en2 bin", 32'(bin2), 32'd1);
    tick();
    check("w1 en3 cnt", 32'(cnt2), 32'd1);
    check("w1 en3 tc", 32'(tc2), 32'd1);
    @(negedge clk);
    en2 = 1'b0;
    tick();
    check("w1 idle tc", 32'(tc2), 32'd0);
    check("w1 idle cnt", 32'(cnt2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
